irrigation_zone_scheduler: RTL and testbench
============================================

IRRIGATION_ZONE_SCHEDULER -- requirements
Module: irrigation_zone_scheduler

Interface
REQ-001 Parameter SHALL be: ZONES, 4, number of irrigation zones (2..16).
REQ-002 Parameter SHALL be: TIMER_W, 10, width of the countdown timer.
REQ-003 Parameter SHALL be: SPRINKLE_TICKS, 300, sprinkler run length in ticks (1..2^TIMER_W-1).
REQ-004 Parameter SHALL be: DRIP_TICKS, 600, dripper run length in ticks (1..2^TIMER_W-1).
REQ-005 Port SHALL be: clock  in  1  single system clock, rising edge.
REQ-006 Port SHALL be: reset_n  in  1  synchronous, active-low reset.
REQ-007 Port SHALL be: tick  in  1  one-cycle time-base pulse.
REQ-008 Port SHALL be: water_low, water_mid, water_high  in  1 each  tank level sensors (1 = water at level).
REQ-009 Port SHALL be: zone_dry  in  ZONES  per-zone earth-dry request.
REQ-010 Port SHALL be: air_dry, low_temperature  in  1 each  climate inputs.
REQ-011 Port SHALL be: abort  in  1  one-cycle pulse ending the current run.
REQ-012 Port SHALL be: zone_valve  out  ZONES  one-hot active zone valve, all 0 when not running.
REQ-013 Port SHALL be: sprinkler_mode  out  1  1 = sprinkler pump, 0 = dripper, valid while running.
REQ-014 Port SHALL be: active_zone  out  clog2(ZONES)  index of current or last zone.
REQ-015 Port SHALL be: remaining  out  TIMER_W  ticks left in the current run.
REQ-016 Port SHALL be: supply_valve, alarm, busy  out  1 each  tank refill, alarm, FSM not IDLE.

Function
REQ-017 conflict SHALL be (water_mid & !water_low) | (water_high & !water_mid).
REQ-018 water_ok SHALL be water_low & !conflict; supply_valve SHALL be registered !conflict & !water_high.
REQ-019 Requested mode SHALL be sprinkler when water_mid & air_dry & !low_temperature, else dripper.
REQ-020 FSM states SHALL be IDLE, RUN, HOLD; all outputs registered.
REQ-021 In IDLE with water_ok, the block SHALL select the first set zone_dry bit searching round-robin from (pointer+1) mod ZONES; the next cycle SHALL be RUN, with that zone_valve bit set, sprinkler_mode = requested mode, and remaining = SPRINKLE_TICKS or DRIP_TICKS.
REQ-022 In RUN, each tick SHALL decrement remaining; a tick with remaining==1 SHALL return to IDLE with valves off, remaining=0, pointer=active_zone.
REQ-023 In RUN, a requested-mode change SHALL update sprinkler_mode and reload remaining with the new mode's length the next cycle, without decrementing.
REQ-024 In RUN, abort or the active zone's zone_dry falling SHALL return to IDLE the next cycle with valves off and pointer=active_zone.
REQ-025 In RUN, !water_ok SHALL enter HOLD: valves off, remaining frozen, active_zone kept.
REQ-026 HOLD SHALL return to RUN with the same zone and remaining when water_ok (subject to REQ-033); abort in HOLD SHALL go to IDLE.
REQ-027 Same-cycle priority SHALL be: fault (HOLD) > abort/drop > mode reload > tick decrement.
REQ-028 alarm SHALL be registered fault | !water_mid, where fault follows REQ-033.
REQ-029 busy SHALL be 1 in RUN and HOLD.
REQ-030 Zone pointer SHALL wrap ZONES-1 -> 0; a single requesting zone SHALL be reselected after its run ends.

Reset
REQ-031 While reset_n=0 at a clock edge the block SHALL enter IDLE with zone_valve=0, sprinkler_mode=0, active_zone=0, remaining=0, supply_valve=0, alarm=0, busy=0, pointer=ZONES-1, fault cleared.
REQ-032 Reset during RUN or HOLD SHALL close all valves on the same edge; no run resumes afterwards.

Configuration
REQ-033 With IRR_FAULT_LATCH_EN defined, conflict SHALL set a sticky fault flag cleared only by reset, and HOLD SHALL not exit to RUN while it is set; without it, fault SHALL equal registered conflict and HOLD SHALL exit one cycle after water_ok returns.

Verification
REQ-034 ZONES=4, zone_dry=4'b0110, water all set, air_dry=1, low_temperature=0 -> zone 1 sprinkles 300 ticks, then zone 2 sprinkles 300 ticks.
REQ-035 Run on zone 2 at remaining=100, air_dry falls -> next cycle sprinkler_mode=0, remaining=600.
REQ-036 Run at remaining=50, water_low=0 -> HOLD, valves 0, remaining 50, alarm=1; water restored -> RUN resumes at 50.
REQ-037 water_high=1 with water_mid=0 -> alarm=1, supply_valve=0; with IRR_FAULT_LATCH_EN the alarm persists after clearing until reset_n=0.
REQ-038 abort and tick in the same cycle at remaining=1 -> IDLE once, pointer advanced once, no underflow.
REQ-039 reset_n=0 mid-run -> all outputs at REQ-031 values on the next edge.

Source files
------------

// File: rtl/irrigation_zone_scheduler.sv
// Irrigation zone scheduler: picks dry zones round-robin, runs each zone for a
// sprinkler or dripper period counted in ticks, pauses on tank water problems.
// Optional build macro IRR_FAULT_LATCH_EN: a tank sensor conflict latches a
// sticky fault (cleared only by reset) that keeps a paused run from resuming.
module irrigation_zone_scheduler #(
  parameter int ZONES          = 4,
  parameter int TIMER_W        = 10,
  parameter int SPRINKLE_TICKS = 300,
  parameter int DRIP_TICKS     = 600
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     water_low,
  input  logic                     water_mid,
  input  logic                     water_high,
  input  logic [ZONES-1:0]         zone_dry,
  input  logic                     air_dry,
  input  logic                     low_temperature,
  input  logic                     abort,
  output logic [ZONES-1:0]         zone_valve,
  output logic                     sprinkler_mode,
  output logic [$clog2(ZONES)-1:0] active_zone,
  output logic [TIMER_W-1:0]       remaining,
  output logic                     supply_valve,
  output logic                     alarm,
  output logic                     busy
);
  localparam int ZW = $clog2(ZONES);
  localparam logic [TIMER_W-1:0] SPR_LEN = TIMER_W'(SPRINKLE_TICKS);
  localparam logic [TIMER_W-1:0] DRP_LEN = TIMER_W'(DRIP_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [ZW-1:0]      ptr_reg, ptr_next;
  logic [ZW-1:0]      zone_reg, zone_next;
  logic [TIMER_W-1:0] rem_reg, rem_next;
  logic               mode_reg, mode_next;
  logic [ZONES-1:0]   valve_reg, valve_next;
  logic               alarm_reg, alarm_next;
  logic               supply_reg, supply_next;
  logic               busy_reg, busy_next;

  logic conflict, water_ok, req_mode, fault, hold_block;
  logic [TIMER_W-1:0] req_len;

  // Sensor plausibility: a higher level reading wet above a dry lower level is impossible.
  assign conflict = (water_mid & ~water_low) | (water_high & ~water_mid);
  assign water_ok = water_low & ~conflict;
  assign req_mode = water_mid & air_dry & ~low_temperature;
  assign req_len  = req_mode ? SPR_LEN : DRP_LEN;

`ifdef IRR_FAULT_LATCH_EN
  logic fault_reg;
  assign fault      = fault_reg | conflict;
  assign hold_block = fault_reg;

  // Sticky fault flag: once a conflict is seen only reset clears it.
  always_ff @(posedge clock) begin
    if (!reset_n) fault_reg <= 1'b0;
    else          fault_reg <= fault;
  end
`else
  assign fault      = conflict;
  assign hold_block = 1'b0;
`endif

  // Candidate zones in round-robin order, starting just after the pointer.
  logic [ZW-1:0]    cand_idx [ZONES];
  logic [ZONES-1:0] cand_hit;
  for (genvar gi = 0; gi < ZONES; gi++) begin : g_cand
    assign cand_idx[gi] = ZW'((32'(ptr_reg) + gi + 1) % ZONES);
    assign cand_hit[gi] = zone_dry[cand_idx[gi]];
  end

  logic          found;
  logic [ZW-1:0] pick;

  // First requesting candidate wins; descending scan lets the lowest offset overwrite.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        found = 1'b1;
        pick  = cand_idx[i];
      end
    end
  end

  // Next-state and next-output logic; priority is hold > abort/drop > reload > tick.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    zone_next  = zone_reg;
    rem_next   = rem_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (water_ok && found) begin
          state_next = RUN;
          zone_next  = pick;
          mode_next  = req_mode;
          rem_next   = req_len;
        end
      end
      RUN: begin
        if (!water_ok) begin
          state_next = HOLD;
        end else if (abort || !zone_dry[zone_reg]) begin
          state_next = IDLE;
          ptr_next   = zone_reg;
          rem_next   = '0;
          mode_next  = 1'b0;
        end else if (req_mode != mode_reg) begin
          mode_next = req_mode;
          rem_next  = req_len;
        end else if (tick) begin
          if (rem_reg == TIMER_W'(1)) begin
            state_next = IDLE;
            ptr_next   = zone_reg;
            rem_next   = '0;
            mode_next  = 1'b0;
          end else begin
            rem_next = rem_reg - TIMER_W'(1);
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_next = IDLE;
          ptr_next   = zone_reg;
          rem_next   = '0;
          mode_next  = 1'b0;
        end else if (water_ok && !hold_block) begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
    valve_next  = (state_next == RUN) ? (ZONES'(1) << zone_next) : '0;
    busy_next   = (state_next != IDLE);
    alarm_next  = fault | ~water_mid;
    supply_next = ~conflict & ~water_high;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= ZW'(ZONES - 1);
      zone_reg   <= '0;
      rem_reg    <= '0;
      mode_reg   <= 1'b0;
      valve_reg  <= '0;
      alarm_reg  <= 1'b0;
      supply_reg <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      zone_reg   <= zone_next;
      rem_reg    <= rem_next;
      mode_reg   <= mode_next;
      valve_reg  <= valve_next;
      alarm_reg  <= alarm_next;
      supply_reg <= supply_next;
      busy_reg   <= busy_next;
    end
  end

  assign zone_valve     = valve_reg;
  assign sprinkler_mode = mode_reg;
  assign active_zone    = zone_reg;
  assign remaining      = rem_reg;
  assign supply_valve   = supply_reg;
  assign alarm          = alarm_reg;
  assign busy           = busy_reg;
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Scoreboard bench for irrigation_zone_scheduler: the driver applies inputs on
// the falling edge, advances a behavioural model and queues the expected
// outputs; a monitor pops and compares just after each rising edge.
module tb_irrigation_zone_scheduler;
  localparam int ZONES = 4;
  localparam int TIMER_W = 10;
  localparam int SPR = 300;
  localparam int DRP = 600;
`ifdef IRR_FAULT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0, tick = 1'b0, water_low = 1'b0, water_mid = 1'b0, water_high = 1'b0;
  logic [ZONES-1:0] zone_dry = '0;
  logic air_dry = 1'b0, low_temperature = 1'b0, abort = 1'b0;
  logic [ZONES-1:0] zone_valve;
  logic sprinkler_mode;
  logic [1:0] active_zone;
  logic [TIMER_W-1:0] remaining;
  logic supply_valve, alarm, busy;

  always #5 clock = ~clock;

  irrigation_zone_scheduler #(
    .ZONES(ZONES), .TIMER_W(TIMER_W), .SPRINKLE_TICKS(SPR), .DRIP_TICKS(DRP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick),
    .water_low(water_low), .water_mid(water_mid), .water_high(water_high),
    .zone_dry(zone_dry), .air_dry(air_dry), .low_temperature(low_temperature),
    .abort(abort), .zone_valve(zone_valve), .sprinkler_mode(sprinkler_mode),
    .active_zone(active_zone), .remaining(remaining), .supply_valve(supply_valve),
    .alarm(alarm), .busy(busy)
  );

  // Pending stimulus, applied at the next falling edge.
  logic n_rst = 1'b0, n_tick = 1'b0, n_wl = 1'b1, n_wm = 1'b1, n_wh = 1'b1;
  logic n_ad = 1'b1, n_lt = 1'b0, n_abort = 1'b0;
  logic [ZONES-1:0] n_zd = '0;

  typedef struct {
    logic [ZONES-1:0] valve;
    logic smode;
    int zone;
    int rem;
    logic sup;
    logic alm;
    logic busy;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0, runs = 0, cyc = 0;

  // Behavioural model state.
  bit m_busy, m_hold, m_smode, m_fault, e_alarm, e_sup;
  int m_zone, m_ptr, m_rem;

  task automatic end_run(input string why);
    runs++;
    $display("run %0d: zone %0d ended (%s) at cycle %0d", runs, m_zone, why, cyc);
    m_busy = 0; m_hold = 0; m_ptr = m_zone; m_rem = 0; m_smode = 0;
  endtask

  task automatic model_step();
    bit conflict, wok, req, found;
    int z;
    exp_t e;
    logic [ZONES-1:0] one;
    if (!n_rst) begin
      m_busy = 0; m_hold = 0; m_zone = 0; m_rem = 0; m_smode = 0;
      m_ptr = ZONES - 1; m_fault = 0; e_alarm = 0; e_sup = 0;
    end else begin
      conflict = (n_wm && !n_wl) || (n_wh && !n_wm);
      wok = n_wl && !conflict;
      req = n_wm && n_ad && !n_lt;
      if (!m_busy) begin
        if (wok) begin
          found = 0;
          for (int k = 1; k <= ZONES && !found; k++) begin
            z = (m_ptr + k) % ZONES;
            if (n_zd[z]) begin
              found = 1; m_busy = 1; m_hold = 0; m_zone = z;
              m_smode = req; m_rem = req ? SPR : DRP;
            end
          end
        end
      end else if (m_hold) begin
        if (n_abort) end_run("abort in hold");
        else if (wok && !(LATCH && m_fault)) m_hold = 0;
      end else begin
        if (!wok) m_hold = 1;
        else if (n_abort) end_run("abort");
        else if (!n_zd[m_zone]) end_run("zone no longer dry");
        else if (req != m_smode) begin m_smode = req; m_rem = req ? SPR : DRP; end
        else if (n_tick) begin
          if (m_rem == 1) end_run("complete");
          else m_rem = m_rem - 1;
        end
      end
      m_fault = LATCH ? (m_fault || conflict) : conflict;
      e_alarm = m_fault || !n_wm;
      e_sup = !conflict && !n_wh;
    end
    one = 1;
    e.valve = (m_busy && !m_hold) ? (one << m_zone) : '0;
    e.smode = m_smode; e.zone = m_zone; e.rem = m_rem;
    e.sup = e_sup; e.alm = e_alarm; e.busy = m_busy;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clock);
    cyc++;
    reset_n = n_rst; tick = n_tick; water_low = n_wl; water_mid = n_wm; water_high = n_wh;
    zone_dry = n_zd; air_dry = n_ad; low_temperature = n_lt; abort = n_abort;
    model_step();
  endtask

  task automatic run_until_rem(input int target, input int bound);
    int n = 0;
    while (!(m_busy && !m_hold && m_rem == target) && n < bound) begin
      step(); n++;
    end
    if (!(m_busy && !m_hold && m_rem == target)) begin
      checks++; errors++;
      $display("FAIL wait_rem: model remaining %0d busy %0d, required %0d within %0d cycles", m_rem, m_busy, target, bound);
    end
  endtask

  // Monitor: compare every registered output one step after each rising edge.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ok = (zone_valve == e.valve) && (int'(active_zone) == e.zone) && (int'(remaining) == e.rem)
          && (supply_valve == e.sup) && (alarm == e.alm) && (busy == e.busy)
          && (!e.busy || sprinkler_mode == e.smode);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL outputs t=%0t: got valve=%b mode=%b zone=%0d rem=%0d sup=%b alarm=%b busy=%b; want valve=%b mode=%b zone=%0d rem=%0d sup=%b alarm=%b busy=%b",
                   $time, zone_valve, sprinkler_mode, active_zone, remaining, supply_valve, alarm, busy,
                   e.valve, e.smode, e.zone, e.rem, e.sup, e.alm, e.busy);
        end
      end
    end
  end

  initial begin
    int wcnt;
    // Reset, then two dry zones with full tank: zone 1 then zone 2 sprinkle 300 ticks.
    n_rst = 0; step(); step();
    n_rst = 1; n_wl = 1; n_wm = 1; n_wh = 1; n_ad = 1; n_lt = 0; n_zd = 4'b0110; n_tick = 1;
    repeat (610) step();
    // Only zone 2 requests; mode change at remaining 100 reloads dripper length.
    n_zd = 4'b0100;
    run_until_rem(100, 1000);
    n_ad = 0; step();
    // abort together with tick at remaining 1 ends the run once; zone 2 is reselected.
    run_until_rem(1, 1000);
    n_abort = 1; step(); n_abort = 0;
    repeat (3) step();
    // Low water mid-run: hold with frozen remaining, then resume.
    run_until_rem(50, 1000);
    n_wl = 0; repeat (5) step();
    n_wl = 1; repeat (5) step();
    // High reading without mid: alarm, no refill; with latching the alarm persists.
    n_wm = 0; repeat (3) step();
    n_wm = 1; repeat (10) step();
    // Reset during a run closes everything on that edge.
    n_rst = 0; step();
    n_rst = 1; repeat (20) step();
    n_rst = 0; step(); n_rst = 1;
    // Randomized segments, each starting from reset.
    for (int s = 0; s < 8; s++) begin
      n_rst = 0; n_wl = 1; n_wm = 1; n_wh = 1; wcnt = 0;
      step(); step();
      n_rst = 1;
      n_zd = ZONES'($urandom);
      for (int c = 0; c < 1500; c++) begin
        n_tick = ($urandom % 4) != 0;
        n_abort = ($urandom % 400) == 0;
        if (($urandom % 200) == 0) n_zd = ZONES'($urandom);
        if (($urandom % 500) == 0) n_ad = ~n_ad;
        if (($urandom % 700) == 0) n_lt = ~n_lt;
        if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0) begin n_wl = 1; n_wm = 1; n_wh = 1; end
        end else if (($urandom % 300) == 0) begin
          {n_wl, n_wm, n_wh} = 3'($urandom);
          wcnt = 1 + int'($urandom % 20);
        end
        n_rst = ($urandom % 3000) != 0;
        step();
        n_rst = 1;
      end
    end
    n_abort = 0;
    @(posedge clock); #2;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
